// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: holds the PC, issues instruction-memory requests and
// fills the IF/ID register, with redirect selection, stall, flush and wait states.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [27:0] jump_addr28_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc_plus4_o,
    output logic        ifid_valid_o
);

    typedef enum logic [0:0] {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [31:0] pc_r, pc_nxt_s;
    logic [31:0] redir_buf_r, redir_buf_nxt_s;
    logic [31:0] ifid_instr_r, ifid_instr_nxt_s;
    logic [31:0] ifid_pc4_r, ifid_pc4_nxt_s;
    logic        ifid_valid_r, ifid_valid_nxt_s;
    logic        req_r;
    logic        redir_s;
    logic [31:0] target_s;
    logic [31:0] seq_pc_s;

    assign seq_pc_s = pc_r + 32'd4;
    assign redir_s  = jr_i | jump_i | branch_taken_i;

    // Redirect target selection, jr has highest priority, then jump, then branch.
    always_comb begin
        target_s = seq_pc_s;
        if (jr_i) begin
            target_s = jr_target_i;
        end else if (jump_i) begin
            target_s = {ifid_pc4_r[31:28], jump_addr28_i};
        end else if (branch_taken_i) begin
            target_s = branch_target_i;
        end else begin
            target_s = seq_pc_s;
        end
    end

    // Next-state, next-PC and IF/ID update logic.
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        redir_buf_nxt_s  = redir_buf_r;
        ifid_instr_nxt_s = ifid_instr_r;
        ifid_pc4_nxt_s   = ifid_pc4_r;
        ifid_valid_nxt_s = ifid_valid_r;
        case (state_r)
            FETCH: begin
                if (!req_r) begin
                    // No request has been issued yet, so a redirect needs no discard.
                    if (redir_s) begin
                        pc_nxt_s         = target_s;
                        ifid_instr_nxt_s = NOP_INSTR;
                        ifid_valid_nxt_s = 1'b0;
                    end else if (flush_i) begin
                        ifid_instr_nxt_s = NOP_INSTR;
                        ifid_valid_nxt_s = 1'b0;
                    end else begin
                        pc_nxt_s = pc_r;
                    end
                end else if (imem_ready_i) begin
                    if (redir_s) begin
                        pc_nxt_s         = target_s;
                        ifid_instr_nxt_s = NOP_INSTR;
                        ifid_valid_nxt_s = 1'b0;
                    end else if (flush_i) begin
                        pc_nxt_s         = stall_i ? pc_r : seq_pc_s;
                        ifid_instr_nxt_s = NOP_INSTR;
                        ifid_valid_nxt_s = 1'b0;
                    end else if (stall_i) begin
                        pc_nxt_s = pc_r;
                    end else begin
                        pc_nxt_s         = seq_pc_s;
                        ifid_instr_nxt_s = imem_data_i;
                        ifid_pc4_nxt_s   = seq_pc_s;
                        ifid_valid_nxt_s = 1'b1;
                    end
                end else begin
                    if (redir_s) begin
                        redir_buf_nxt_s  = target_s;
                        state_nxt_s      = DISCARD;
                        ifid_instr_nxt_s = NOP_INSTR;
                        ifid_valid_nxt_s = 1'b0;
                    end else if (stall_i && !flush_i) begin
                        ifid_valid_nxt_s = ifid_valid_r;
                    end else begin
                        ifid_instr_nxt_s = NOP_INSTR;
                        ifid_valid_nxt_s = 1'b0;
                    end
                end
            end
            DISCARD: begin
                // The outstanding word is on the wrong path; newest redirect wins.
                if (redir_s) begin
                    redir_buf_nxt_s = target_s;
                end else begin
                    redir_buf_nxt_s = redir_buf_r;
                end
                if (redir_s || flush_i) begin
                    ifid_instr_nxt_s = NOP_INSTR;
                    ifid_valid_nxt_s = 1'b0;
                end else begin
                    ifid_valid_nxt_s = ifid_valid_r;
                end
                if (imem_ready_i) begin
                    pc_nxt_s    = redir_s ? target_s : redir_buf_r;
                    state_nxt_s = FETCH;
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            default: begin
                state_nxt_s      = FETCH;
                pc_nxt_s         = RESET_PC;
                ifid_instr_nxt_s = NOP_INSTR;
                ifid_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State, PC, redirect buffer and IF/ID registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r      <= FETCH;
            pc_r         <= RESET_PC;
            redir_buf_r  <= 32'h0000_0000;
            ifid_instr_r <= NOP_INSTR;
            ifid_pc4_r   <= 32'h0000_0000;
            ifid_valid_r <= 1'b0;
            req_r        <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            redir_buf_r  <= redir_buf_nxt_s;
            ifid_instr_r <= ifid_instr_nxt_s;
            ifid_pc4_r   <= ifid_pc4_nxt_s;
            ifid_valid_r <= ifid_valid_nxt_s;
            req_r        <= 1'b1;
        end
    end

    assign imem_req_o      = req_r;
    assign imem_addr_o     = pc_r;
    assign pc_o            = pc_r;
    assign ifid_instr_o    = ifid_instr_r;
    assign ifid_pc_plus4_o = ifid_pc4_r;
    assign ifid_valid_o    = ifid_valid_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: one-cycle vector table plus hand-written
// wait-state, newest-redirect and mid-operation reset sequences.
module tb_fetch_pc_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i, flush_i, branch_taken_i, jump_i, jr_i, imem_ready_i;
    logic [31:0] branch_target_i, jr_target_i, imem_data_i;
    logic [27:0] jump_addr28_i;
    logic        imem_req_o, ifid_valid_o;
    logic [31:0] imem_addr_o, pc_o, ifid_instr_o, ifid_pc_plus4_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        stall, flush, br;
        logic [31:0] bt;
        logic        jmp;
        logic [27:0] ja;
        logic        jr;
        logic [31:0] jt;
        logic        rdy;
        logic [31:0] data;
        logic [31:0] e_pc, e_instr, e_pc4;
        logic        e_valid;
    } vec_t;

    vec_t vecs[22];

    fetch_pc_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .jump_i(jump_i), .jump_addr28_i(jump_addr28_i), .jr_i(jr_i),
        .jr_target_i(jr_target_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ready_i(imem_ready_i), .imem_data_i(imem_data_i), .pc_o(pc_o),
        .ifid_instr_o(ifid_instr_o), .ifid_pc_plus4_o(ifid_pc_plus4_o),
        .ifid_valid_o(ifid_valid_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic s, input logic f, input logic b, input logic [31:0] bt,
                                input logic j, input logic [27:0] ja, input logic r,
                                input logic [31:0] jt, input logic rdy, input logic [31:0] d,
                                input logic [31:0] epc, input logic [31:0] ei,
                                input logic [31:0] ep4, input logic ev);
        vec_t v;
        v.stall = s; v.flush = f; v.br = b; v.bt = bt; v.jmp = j; v.ja = ja;
        v.jr = r; v.jt = jt; v.rdy = rdy; v.data = d;
        v.e_pc = epc; v.e_instr = ei; v.e_pc4 = ep4; v.e_valid = ev;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        stall_i = 1'b0; flush_i = 1'b0; branch_taken_i = 1'b0; jump_i = 1'b0; jr_i = 1'b0;
        branch_target_i = 32'h0; jump_addr28_i = 28'h0; jr_target_i = 32'h0;
        imem_ready_i = 1'b0; imem_data_i = 32'h0;
    endtask

    task automatic apply_vec(input vec_t v, input string name);
        stall_i = v.stall; flush_i = v.flush; branch_taken_i = v.br; branch_target_i = v.bt;
        jump_i = v.jmp; jump_addr28_i = v.ja; jr_i = v.jr; jr_target_i = v.jt;
        imem_ready_i = v.rdy; imem_data_i = v.data;
        @(posedge clk_i);
        @(negedge clk_i);
        chk({name, ".pc"}, pc_o, v.e_pc);
        chk({name, ".addr"}, imem_addr_o, v.e_pc);
        chk({name, ".instr"}, ifid_instr_o, v.e_instr);
        chk({name, ".pc4"}, ifid_pc_plus4_o, v.e_pc4);
        chk({name, ".valid"}, {31'h0, ifid_valid_o}, {31'h0, v.e_valid});
        chk({name, ".req"}, {31'h0, imem_req_o}, 32'h1);
    endtask

    initial begin
        // stall flush br bt jmp ja jr jt rdy data | pc instr pc4 valid
        vecs[0]  = mk(0,0,0,32'h0,0,28'h0,0,32'h0,1,32'hA000_0000, 32'h4, 32'hA000_0000, 32'h4, 1);
        vecs[1]  = mk(0,0,0,32'h0,0,28'h0,0,32'h0,1,32'hA000_0001, 32'h8, 32'hA000_0001, 32'h8, 1);
        vecs[2]  = mk(0,0,0,32'h0,0,28'h0,0,32'h0,1,32'hA000_0002, 32'hC, 32'hA000_0002, 32'hC, 1);
        vecs[3]  = mk(0,0,0,32'h0,0,28'h0,0,32'h0,1,32'hA000_0003, 32'h10, 32'hA000_0003, 32'h10, 1);
        vecs[4]  = mk(0,0,0,32'h0,0,28'h0,1,32'h4000_000C,1,32'hDEAD_0000, 32'h4000_000C, NOP, 32'h10, 0);
        vecs[5]  = mk(0,0,0,32'h0,0,28'h0,0,32'h0,1,32'hB000_0000, 32'h4000_0010, 32'hB000_0000, 32'h4000_0010, 1);
        vecs[6]  = mk(0,0,0,32'h0,1,28'h000_0100,0,32'h0,1,32'hDEAD_0001, 32'h4000_0100, NOP, 32'h4000_0010, 0);
        vecs[7]  = mk(0,0,1,32'h0000_3000,1,28'h0FF_FFF0,1,32'h0000_2000,1,32'hDEAD_0002, 32'h2000, NOP, 32'h4000_0010, 0);
        vecs[8]  = mk(0,0,1,32'h0000_0080,0,28'h0,0,32'h0,1,32'hDEAD_0003, 32'h80, NOP, 32'h4000_0010, 0);
        vecs[9]  = mk(0,0,0,32'h0,0,28'h0,0,32'h0,1,32'hC000_0000, 32'h84, 32'hC000_0000, 32'h84, 1);
        vecs[10] = mk(1,0,0,32'h0,0,28'h0,0,32'h0,1,32'hC000_0001, 32'h84, 32'hC000_0000, 32'h84, 1);
        vecs[11] = mk(1,0,0,32'h0,0,28'h0,0,32'h0,1,32'hC000_0001, 32'h84, 32'hC000_0000, 32'h84, 1);
        vecs[12] = mk(0,0,0,32'h0,0,28'h0,0,32'h0,1,32'hC000_0001, 32'h88, 32'hC000_0001, 32'h88, 1);
        vecs[13] = mk(0,1,0,32'h0,0,28'h0,0,32'h0,1,32'hC000_0002, 32'h8C, NOP, 32'h88, 0);
        vecs[14] = mk(0,0,0,32'h0,0,28'h0,0,32'h0,0,32'h0, 32'h8C, NOP, 32'h88, 0);
        vecs[15] = mk(0,0,0,32'h0,0,28'h0,0,32'h0,1,32'hC000_0003, 32'h90, 32'hC000_0003, 32'h90, 1);
        vecs[16] = mk(1,0,0,32'h0,0,28'h0,0,32'h0,0,32'h0, 32'h90, 32'hC000_0003, 32'h90, 1);
        vecs[17] = mk(1,1,0,32'h0,0,28'h0,0,32'h0,0,32'h0, 32'h90, NOP, 32'h90, 0);
        vecs[18] = mk(0,0,0,32'h0,0,28'h0,1,32'hFFFF_FFFC,1,32'hDEAD_0004, 32'hFFFF_FFFC, NOP, 32'h90, 0);
        vecs[19] = mk(0,0,0,32'h0,0,28'h0,0,32'h0,1,32'hE000_0000, 32'h0, 32'hE000_0000, 32'h0, 1);
        vecs[20] = mk(0,0,0,32'h0,0,28'h0,0,32'h0,1,32'hE000_0001, 32'h4, 32'hE000_0001, 32'h4, 1);
        vecs[21] = mk(0,0,0,32'h0,0,28'h0,0,32'h0,1,32'hE000_0002, 32'h8, 32'hE000_0002, 32'h8, 1);

        idle();
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst.pc", pc_o, 32'h0);
        chk("rst.req", {31'h0, imem_req_o}, 32'h0);
        chk("rst.instr", ifid_instr_o, NOP);
        chk("rst.pc4", ifid_pc_plus4_o, 32'h0);
        chk("rst.valid", {31'h0, ifid_valid_o}, 32'h0);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rel.req", {31'h0, imem_req_o}, 32'h1);
        chk("rel.pc", pc_o, 32'h0);

        for (int i = 0; i < 22; i++) begin
            apply_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Wait states with a branch at pc=8: address held, late word dropped.
        apply_vec(mk(0,0,1,32'h40,0,28'h0,0,32'h0,0,32'h0, 32'h8, NOP, 32'h8, 0), "ws1");
        apply_vec(mk(0,0,0,32'h0,0,28'h0,0,32'h0,0,32'h0, 32'h8, NOP, 32'h8, 0), "ws2");
        apply_vec(mk(0,0,0,32'h0,0,28'h0,0,32'h0,0,32'h0, 32'h8, NOP, 32'h8, 0), "ws3");
        apply_vec(mk(0,0,0,32'h0,0,28'h0,0,32'h0,1,32'hBAD0_0000, 32'h40, NOP, 32'h8, 0), "ws4");
        apply_vec(mk(0,0,0,32'h0,0,28'h0,0,32'h0,1,32'hF000_0000, 32'h44, 32'hF000_0000, 32'h44, 1), "ws5");

        // Newer redirect while discarding replaces the buffered target.
        apply_vec(mk(0,0,1,32'h200,0,28'h0,0,32'h0,0,32'h0, 32'h44, NOP, 32'h44, 0), "nw1");
        apply_vec(mk(0,0,0,32'h0,0,28'h0,1,32'h300,0,32'h0, 32'h44, NOP, 32'h44, 0), "nw2");
        apply_vec(mk(0,0,0,32'h0,0,28'h0,0,32'h0,1,32'hBAD0_0001, 32'h300, NOP, 32'h44, 0), "nw3");
        apply_vec(mk(0,0,0,32'h0,0,28'h0,0,32'h0,1,32'hF000_0001, 32'h304, 32'hF000_0001, 32'h304, 1), "nw4");

        // Reset asserted while in DISCARD drops the pending redirect.
        apply_vec(mk(0,0,1,32'h500,0,28'h0,0,32'h0,0,32'h0, 32'h304, NOP, 32'h304, 0), "md1");
        idle();
        #2 rst_i = 1'b0;
        #1;
        chk("mrst.pc", pc_o, 32'h0);
        chk("mrst.valid", {31'h0, ifid_valid_o}, 32'h0);
        chk("mrst.req", {31'h0, imem_req_o}, 32'h0);
        chk("mrst.pc4", ifid_pc_plus4_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("mrel.pc", pc_o, 32'h0);
        apply_vec(mk(0,0,0,32'h0,0,28'h0,0,32'h0,1,32'h1234_5678, 32'h4, 32'h1234_5678, 32'h4, 1), "mrel1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
